// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: radix-2 shift-add multiply,
// restoring divide, one iteration per cycle, with a stall request held while busy.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MulDivE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMD,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [2:0]        f3_q, f3_d;

    logic              sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   acc_hi, acc_lo, quot_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   result;

    // Operand signedness per funct3: MULH both, MULHSU rs1 only, DIV/REM both.
    always_comb begin
        sign_a   = Funct3E[2] ? ~Funct3E[0] : (Funct3E[1:0] == 2'b01 || Funct3E[1:0] == 2'b10);
        sign_b   = Funct3E[2] ? ~Funct3E[0] : (Funct3E[1:0] == 2'b01);
        neg_a    = sign_a & SrcAE[XLEN-1];
        neg_b    = sign_b & SrcBE[XLEN-1];
        abs_a    = neg_a ? -SrcAE : SrcAE;
        abs_b    = neg_b ? -SrcBE : SrcBE;
        div_zero = (SrcBE == '0);
        div_ovf  = ~Funct3E[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
    end

    // One datapath iteration: acc holds {hi, multiplier} for MUL and {rem, quot} for DIV.
    always_comb begin
        acc_hi   = acc_q[2*XLEN-1:XLEN];
        acc_lo   = acc_q[XLEN-1:0];
        mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rem  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_rem - {1'b0, opnd_q};
        div_ge   = (div_rem >= {1'b0, opnd_q});
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_lo : acc_lo;
        rem_fix  = neg_rem_q ? -acc_hi : acc_hi;
        case (f3_q)
            3'b000:                 result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quot_fix;
            default:                result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        f3_d      = f3_q;
        case (state_q)
            IDLE: begin
                if (MulDivE && !FlushE) begin
                    f3_d      = Funct3E;
                    cnt_d     = CW'(XLEN);
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    if (!Funct3E[2]) begin
                        opnd_d  = abs_a;
                        acc_d   = {{XLEN{1'b0}}, abs_b};
                        state_d = MUL;
                    end else if (div_zero || div_ovf) begin
                        // Results are final as loaded, so the DONE sign fix is disabled.
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        cnt_d     = '0;
                        acc_d     = div_zero ? {SrcAE, {XLEN{1'b1}}} : {{XLEN{1'b0}}, SrcAE};
                        state_d   = DONE;
                    end else begin
                        opnd_d  = abs_b;
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d   = {mul_sum, acc_lo[XLEN-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = FlushE ? IDLE : (cnt_q == 1 ? DONE : MUL);
            end
            DIV: begin
                acc_d   = div_ge ? {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1}
                                 : {div_rem[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                state_d = FlushE ? IDLE : (cnt_q == 1 ? DONE : DIV);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            f3_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            f3_q      <= f3_d;
        end
    end

    always_comb begin
        StallMD = ~reset & (((state_q == IDLE) & MulDivE & ~FlushE) |
                            (state_q == MUL) | (state_q == DIV));
        DoneE   = (state_q == DONE) & ~FlushE;
        ResultE = DoneE ? result : '0;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, corner-case sequences,
// and random ops compared against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        MulDivE;
    logic [2:0]  Funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        StallMD;
    logic        DoneE;
    logic [31:0] ResultE;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .MulDivE(MulDivE), .Funct3E(Funct3E),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
        .StallMD(StallMD), .DoneE(DoneE), .ResultE(ResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from RV32M semantics using wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          qa, qb;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        qa  = $signed(a);
        qb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(qa / qb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(qa % qb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Starts one op in cycle 0 and waits for DoneE; lat=-1 if it never arrives.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat, output bit stall_ok);
        @(negedge clk);
        MulDivE = 1'b1;
        Funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        stall_ok = 1'b1;
        lat      = -1;
        res      = '0;
        #1;
        if (StallMD !== 1'b1) stall_ok = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (DoneE === 1'b1) begin
                lat = c;
                res = ResultE;
                if (StallMD !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (StallMD !== 1'b1) stall_ok = 1'b0;
        end
        @(negedge clk);
        MulDivE = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          stall_ok;
        applyStimulus(f3, a, b, res, lat, stall_ok);
        checkOutput({name, " result"}, res, exp_res);
        checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " stall"}, {31'b0, stall_ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a, b;
        logic [2:0]  f3;
        bit          saw_done;
        int          cyc;

        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        33});
        vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         33});
        vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'b111, 32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1});
        vecs.push_back('{3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33});

        reset   = 1'b1;
        MulDivE = 1'b0;
        Funct3E = '0;
        SrcAE   = '0;
        SrcBE   = '0;
        FlushE  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset StallMD", {31'b0, StallMD}, 32'd0);
        checkOutput("reset DoneE", {31'b0, DoneE}, 32'd0);
        checkOutput("reset ResultE", ResultE, 32'd0);
        reset = 1'b0;

        foreach (vecs[i])
            run_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                          vecs[i].exp_res, vecs[i].exp_lat);

        // Flush a multiply in cycle 10: no DoneE, stall drops next cycle.
        @(negedge clk);
        MulDivE = 1'b1; Funct3E = 3'b000; SrcAE = 32'd5; SrcBE = 32'd6;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("flush c10 StallMD", {31'b0, StallMD}, 32'd1);
        FlushE  = 1'b1;
        MulDivE = 1'b0;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        checkOutput("flush c11 StallMD", {31'b0, StallMD}, 32'd0);
        checkOutput("flush c11 DoneE", {31'b0, DoneE}, 32'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (DoneE === 1'b1) saw_done = 1'b1;
        end
        checkOutput("flush no DoneE", {31'b0, saw_done}, 32'd0);
        run_and_check("after flush", 3'b011, 32'd9, 32'd9, 32'd0, 33);

        // Reset in cycle 5 of a divide aborts it immediately.
        @(negedge clk);
        MulDivE = 1'b1; Funct3E = 3'b100; SrcAE = 32'd100; SrcBE = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset StallMD", {31'b0, StallMD}, 32'd0);
        checkOutput("midreset DoneE", {31'b0, DoneE}, 32'd0);
        checkOutput("midreset ResultE", ResultE, 32'd0);
        MulDivE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (DoneE === 1'b1) saw_done = 1'b1;
        end
        checkOutput("midreset no DoneE", {31'b0, saw_done}, 32'd0);

        // Back-to-back MUL 3*4 then DIVU 12/5 with MulDivE held high.
        @(negedge clk);
        MulDivE = 1'b1; Funct3E = 3'b000; SrcAE = 32'd3; SrcBE = 32'd4;
        cyc = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (DoneE === 1'b1) begin cyc = c; res = ResultE; break; end
        end
        checkOutput("b2b first latency", 32'(cyc), 32'd33);
        checkOutput("b2b first result", res, 32'd12);
        Funct3E = 3'b101; SrcAE = 32'd12; SrcBE = 32'd5;
        @(posedge clk);
        #1;
        checkOutput("b2b c34 StallMD", {31'b0, StallMD}, 32'd1);
        cyc = -1;
        for (int c = 35; c <= 150; c++) begin
            @(posedge clk);
            #1;
            if (DoneE === 1'b1) begin cyc = c; res = ResultE; break; end
        end
        checkOutput("b2b second latency", 32'(cyc), 32'd67);
        checkOutput("b2b second result", res, 32'd2);
        @(negedge clk);
        MulDivE = 1'b0;

        // Random ops, biased towards divisor zero and signed overflow corners.
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_and_check($sformatf("rand%0d f3=%0d", n, f3), f3, a, b,
                          ref_model(f3, a, b), ref_latency(f3, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M execution sequencer in the EX stage of the pipelined core. It accepts a multiply/divide op, runs a radix-2 shift-add multiplier or restoring divider over XLEN cycles, and holds the pipeline through a stall request. The hazard unit ORs this request into StallF/StallD and a new StallE. Result and done are presented to the EX-stage result mux.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN)+1

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
MulDivE  input  1  valid M-extension instruction currently in EX
Funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  XLEN  rs1 operand, already forwarded
SrcBE  input  XLEN  rs2 operand, already forwarded
FlushE  input  1  kill the EX instruction (branch taken or load-use bubble)
StallMD  output  1  hold F/D/E and bubble M while the op is in progress
DoneE  output  1  one-cycle pulse; ResultE is valid and the instruction advances
ResultE  output  XLEN  final result; meaningful only while DoneE=1

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset forces IDLE and clears counter, accumulators and registered sign flags; DoneE=0, StallMD=0, ResultE=0.
- Reset mid-operation: abort at once. No DoneE is produced.
- IDLE, MulDivE=1, FlushE=0:
  - Latch |SrcAE| and |SrcBE|. Signedness comes from funct3: MULH signs both operands, MULHSU signs only rs1, DIV/REM sign both, the unsigned ops sign neither.
  - Latch the result sign and funct3. Load counter = XLEN.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- IDLE divide special cases go to DONE directly, with the result latched:
  - Divisor zero: quotient all-ones, remainder = SrcAE.
  - Signed overflow (SrcAE = 0x80000000, SrcBE = all-ones): quotient = 0x80000000, remainder 0.
- MUL: each cycle, if multiplier lsb=1 add the multiplicand into the upper half of a 2*XLEN product. Shift right by 1 with carry-in. Decrement the counter.
- DIV: each cycle, shift {rem,quot} left by 1. If rem >= divisor, subtract and set the quotient lsb. Decrement the counter.
- On the cycle the counter reaches 1, go to DONE.
- DONE:
  - Apply the sign fix: negate the product if the signs differ; negate the quotient if the signs differ; negate the remainder if the dividend was negative.
  - Select the low half (MUL), high half (MULH*), quotient or remainder.
  - DoneE=1, then go to IDLE.
  - MulDivE is still high for the same instruction in this cycle and must not restart.
- StallMD (combinational) = (state==IDLE & MulDivE & ~FlushE) | state==MUL | state==DIV. It is 0 in DONE so the instruction advances.
- Latency, where cycle 0 is the start cycle:
  - Normal op: StallMD=1 for cycles 0..XLEN (33 cycles), DoneE in cycle XLEN+1 = 33.
  - Special divide case: StallMD=1 in cycle 0 only, DoneE in cycle 1.
- FlushE=1 in MUL/DIV/DONE: go to IDLE at the next edge. No DoneE (DoneE is gated by ~FlushE), and StallMD drops in the next cycle.
- FlushE=1 in IDLE: the start is ignored.
- Back-to-back ops: the cycle after DONE is IDLE. If the next EX instruction is M-type, it starts in that cycle with no gap bubble.
- All arithmetic is unsigned at XLEN or XLEN+1 bits on magnitudes. Negation is two's complement modulo 2^XLEN (2*XLEN for the product).

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3): StallMD high cycles 0..32; cycle 33 DoneE=1, ResultE=0xFFFFFFEB, StallMD=0.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. Each gives DoneE in cycle 33.
- DIVU 5 / 0 -> 0xFFFFFFFF with DoneE in cycle 1. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Start MUL, assert FlushE in cycle 10: state IDLE in cycle 11, StallMD=0, no DoneE. Assert reset in cycle 5 of a DIV: outputs 0 immediately.
- Back-to-back MUL 3*4 then DIVU 12/5 with MulDivE held high: DoneE in cycle 33 with 12; second op starts in cycle 34; DoneE in cycle 67 with 2.
